// File: rtl/sys_if_axil_bridge.sv
// AXI4-Lite slave to sys_if master bridge: one access at a time, with
// read-modify-write for partial strobes and DECERR for out-of-window addresses.
module sys_if_axil_bridge #(
  parameter logic [31:0] ADDR_MASK = 32'h0000_00FF
) (
  input  logic        sys_if_clk,
  input  logic        sys_if_rstn,
  input  logic [31:0] s_axil_awaddr,
  input  logic        s_axil_awvalid,
  output logic        s_axil_awready,
  input  logic [31:0] s_axil_wdata,
  input  logic [3:0]  s_axil_wstrb,
  input  logic        s_axil_wvalid,
  output logic        s_axil_wready,
  output logic [1:0]  s_axil_bresp,
  output logic        s_axil_bvalid,
  input  logic        s_axil_bready,
  input  logic [31:0] s_axil_araddr,
  input  logic        s_axil_arvalid,
  output logic        s_axil_arready,
  output logic [31:0] s_axil_rdata,
  output logic [1:0]  s_axil_rresp,
  output logic        s_axil_rvalid,
  input  logic        s_axil_rready,
  output logic        sys_if_wen,
  output logic [31:0] sys_if_addr,
  output logic [31:0] sys_if_wdata,
  input  logic [31:0] sys_if_rdata
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE, WR_RMW, WR_EXEC, WR_RESP, RD_CAPT, RD_RESP
  } state_t;

  state_t          state_q, state_d;
  logic            aw_held_q, aw_held_d;
  logic            w_held_q, w_held_d;
  logic [AW-1:0]   awaddr_q, awaddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic            last_wr_q, last_wr_d;
  logic            wen_q, wen_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   sys_wdata_q, sys_wdata_d;
  logic            bvalid_q, bvalid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic            rvalid_q, rvalid_d;
  logic [1:0]      rresp_q, rresp_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic            idle, ar_grant, aw_hs, w_hs, wr_commit;
  logic [AW-1:0]   cur_awaddr;
  logic [DW-1:0]   cur_wdata;
  logic [SW-1:0]   cur_wstrb;

  function automatic logic dec_err(input logic [AW-1:0] a);
    return |(a & ~ADDR_MASK);
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] wd,
                                          input logic [SW-1:0] st,
                                          input logic [DW-1:0] rd);
    logic [DW-1:0] m;
    for (int i = 0; i < int'(SW); i++) begin
      m[8*i +: 8] = st[i] ? wd[8*i +: 8] : rd[8*i +: 8];
    end
    return m;
  endfunction

  // Handshake arbitration: a pending full write and a read alternate via last_wr.
  assign idle           = sys_if_rstn && (state_q == IDLE);
  assign s_axil_arready = idle && !aw_held_q && !w_held_q &&
                          !(s_axil_awvalid && s_axil_wvalid && !last_wr_q);
  assign ar_grant       = s_axil_arready && s_axil_arvalid;
  assign s_axil_awready = idle && !aw_held_q && !ar_grant;
  assign s_axil_wready  = idle && !w_held_q && !ar_grant;

  assign aw_hs      = s_axil_awvalid && s_axil_awready;
  assign w_hs       = s_axil_wvalid && s_axil_wready;
  assign cur_awaddr = aw_held_q ? awaddr_q : s_axil_awaddr;
  assign cur_wdata  = w_held_q ? wdata_q : s_axil_wdata;
  assign cur_wstrb  = w_held_q ? wstrb_q : s_axil_wstrb;
  assign wr_commit  = idle && (aw_held_q || aw_hs) && (w_held_q || w_hs);

  always_comb begin
    state_d     = state_q;
    aw_held_d   = aw_held_q;
    w_held_d    = w_held_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    last_wr_d   = last_wr_q;
    wen_d       = 1'b0;
    addr_d      = addr_q;
    sys_wdata_d = sys_wdata_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    rvalid_d    = rvalid_q;
    rresp_d     = rresp_q;
    rdata_d     = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_axil_awaddr;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = s_axil_wdata;
          wstrb_d  = s_axil_wstrb;
        end
        if (wr_commit) begin
          if (dec_err(cur_awaddr)) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_DECERR;
            state_d  = WR_RESP;
          end else if (cur_wstrb == '0) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_OKAY;
            state_d  = WR_RESP;
          end else if (cur_wstrb == '1) begin
            addr_d      = {cur_awaddr[AW-1:2], 2'b00};
            sys_wdata_d = cur_wdata;
            wen_d       = 1'b1;
            state_d     = WR_EXEC;
          end else begin
            addr_d  = {cur_awaddr[AW-1:2], 2'b00};
            state_d = WR_RMW;
          end
        end else if (ar_grant) begin
          if (dec_err(s_axil_araddr)) begin
            rvalid_d = 1'b1;
            rresp_d  = RESP_DECERR;
            rdata_d  = '0;
            state_d  = RD_RESP;
          end else begin
            addr_d  = {s_axil_araddr[AW-1:2], 2'b00};
            state_d = RD_CAPT;
          end
        end
      end
      WR_RMW: begin
        sys_wdata_d = merge(wdata_q, wstrb_q, sys_if_rdata);
        wen_d       = 1'b1;
        state_d     = WR_EXEC;
      end
      WR_EXEC: begin
        bvalid_d  = 1'b1;
        bresp_d   = RESP_OKAY;
        last_wr_d = 1'b1;
        state_d   = WR_RESP;
      end
      WR_RESP: begin
        if (s_axil_bready) begin
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      RD_CAPT: begin
        rdata_d   = sys_if_rdata;
        rresp_d   = RESP_OKAY;
        rvalid_d  = 1'b1;
        last_wr_d = 1'b0;
        state_d   = RD_RESP;
      end
      RD_RESP: begin
        if (s_axil_rready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_if_clk) begin
    if (!sys_if_rstn) begin
      state_q     <= IDLE;
      aw_held_q   <= 1'b0;
      w_held_q    <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      last_wr_q   <= 1'b0;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      sys_wdata_q <= '0;
      bvalid_q    <= 1'b0;
      bresp_q     <= '0;
      rvalid_q    <= 1'b0;
      rresp_q     <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      aw_held_q   <= aw_held_d;
      w_held_q    <= w_held_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      last_wr_q   <= last_wr_d;
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      sys_wdata_q <= sys_wdata_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      rvalid_q    <= rvalid_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
    end
  end

  assign sys_if_wen    = wen_q;
  assign sys_if_addr   = addr_q;
  assign sys_if_wdata  = sys_wdata_q;
  assign s_axil_bvalid = bvalid_q;
  assign s_axil_bresp  = bresp_q;
  assign s_axil_rvalid = rvalid_q;
  assign s_axil_rresp  = rresp_q;
  assign s_axil_rdata  = rdata_q;

endmodule

// File: tb/tb_sys_if_axil_bridge.sv
// Directed and randomized AXI4-Lite traffic against a word-array register file,
// checked against a byte-lane memory model kept in the bench.
module tb_sys_if_axil_bridge;

  localparam logic [31:0] MASK = 32'h0000_00FF;

  logic        clk, rstn;
  logic [31:0] s_axil_awaddr, s_axil_wdata, s_axil_araddr, s_axil_rdata;
  logic [31:0] sys_if_addr, sys_if_wdata, sys_if_rdata;
  logic [3:0]  s_axil_wstrb;
  logic [1:0]  s_axil_bresp, s_axil_rresp;
  logic        s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
  logic        s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready;
  logic        s_axil_rvalid, s_axil_rready, sys_if_wen;

  int          checks, failures, cyc, wen_cnt, wen_edge;
  logic [31:0] wen_data, wen_addr;
  logic [31:0] regfile [64];
  logic [31:0] exp_mem [64];

  sys_if_axil_bridge #(.ADDR_MASK(MASK)) dut (
    .sys_if_clk(clk), .sys_if_rstn(rstn),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .sys_if_wen(sys_if_wen), .sys_if_addr(sys_if_addr),
    .sys_if_wdata(sys_if_wdata), .sys_if_rdata(sys_if_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file behind the bridge, plus a log of every write strobe.
  assign sys_if_rdata = regfile[sys_if_addr[7:2]];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc < 2) begin
      for (int i = 0; i < 64; i++) regfile[i] <= 32'h0;
    end else if (sys_if_wen) begin
      regfile[sys_if_addr[7:2]] <= sys_if_wdata;
    end
    if (sys_if_wen) begin
      wen_cnt  <= wen_cnt + 1;
      wen_edge <= cyc;
      wen_data <= sys_if_wdata;
      wen_addr <= sys_if_addr;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit is_decerr(input logic [31:0] a);
    return (a & ~MASK) != 32'h0;
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int w_delay, input int b_hold);
    int hs, lat, wen0, t, exp_lat;
    bit aw_done, w_done, de, stable;
    logic [31:0] bm, merged;
    logic [1:0]  r0;
    de     = is_decerr(addr);
    bm     = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    merged = (exp_mem[addr[7:2]] & ~bm) | (data & bm);
    wen0 = wen_cnt; aw_done = 0; w_done = 0; hs = 0;
    @(negedge clk);
    s_axil_awaddr = addr; s_axil_awvalid = 1'b1;
    s_axil_wdata = data; s_axil_wstrb = strb; s_axil_wvalid = (w_delay == 0);
    t = 0;
    while (!(aw_done && w_done) && t < 40) begin
      #1;
      if (s_axil_awvalid && s_axil_awready) begin aw_done = 1; hs = cyc; end
      if (s_axil_wvalid && s_axil_wready) begin w_done = 1; hs = cyc; end
      @(negedge clk);
      if (aw_done) s_axil_awvalid = 1'b0;
      if (w_done) s_axil_wvalid = 1'b0;
      t++;
      if (!w_done && t >= w_delay) s_axil_wvalid = 1'b1;
    end
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    chk("wr_handshake", 32'(aw_done && w_done), 32'd1);
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      if (s_axil_bvalid) begin lat = cyc - hs; break; end
      @(negedge clk);
    end
    exp_lat = (de || strb == 4'h0) ? 1 : (strb == 4'hF) ? 2 : 3;
    chk("b_latency", 32'(lat), 32'(exp_lat));
    chk("bresp", 32'(s_axil_bresp), de ? 32'd3 : 32'd0);
    r0 = s_axil_bresp; stable = 1;
    for (int j = 0; j < b_hold; j++) begin
      @(negedge clk);
      if (!s_axil_bvalid || s_axil_bresp !== r0) stable = 0;
    end
    chk("b_stable", 32'(stable), 32'd1);
    s_axil_bready = 1'b1;
    @(negedge clk);
    s_axil_bready = 1'b0;
    chk("b_drop", 32'(s_axil_bvalid), 32'd0);
    if (de || strb == 4'h0) begin
      chk("wen_count_none", 32'(wen_cnt - wen0), 32'd0);
    end else begin
      chk("wen_count", 32'(wen_cnt - wen0), 32'd1);
      chk("wen_cycle", 32'(wen_edge - hs), (strb == 4'hF) ? 32'd1 : 32'd2);
      chk("wen_data", wen_data, merged);
      chk("wen_addr", wen_addr, {addr[31:2], 2'b00});
      exp_mem[addr[7:2]] = merged;
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input int r_hold);
    int hs, lat, wen0;
    bit done, de, stable;
    logic [31:0] d0;
    de = is_decerr(addr); wen0 = wen_cnt; done = 0; hs = 0;
    @(negedge clk);
    s_axil_araddr = addr; s_axil_arvalid = 1'b1;
    for (int t = 0; t < 40 && !done; t++) begin
      #1;
      if (s_axil_arvalid && s_axil_arready) begin done = 1; hs = cyc; end
      @(negedge clk);
    end
    s_axil_arvalid = 1'b0;
    chk("rd_handshake", 32'(done), 32'd1);
    if (!de) chk("rd_sys_addr", sys_if_addr, {addr[31:2], 2'b00});
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      if (s_axil_rvalid) begin lat = cyc - hs; break; end
      @(negedge clk);
    end
    chk("r_latency", 32'(lat), de ? 32'd1 : 32'd2);
    chk("rdata", s_axil_rdata, de ? 32'h0 : exp_mem[addr[7:2]]);
    chk("rresp", 32'(s_axil_rresp), de ? 32'd3 : 32'd0);
    d0 = s_axil_rdata; stable = 1;
    for (int j = 0; j < r_hold; j++) begin
      @(negedge clk);
      if (!s_axil_rvalid || s_axil_rdata !== d0) stable = 0;
    end
    chk("r_stable", 32'(stable), 32'd1);
    s_axil_rready = 1'b1;
    @(negedge clk);
    s_axil_rready = 1'b0;
    chk("r_drop", 32'(s_axil_rvalid), 32'd0);
    chk("rd_no_wen", 32'(wen_cnt - wen0), 32'd0);
  endtask

  initial begin
    int n, both, wen0;
    logic [3:0]  order;
    logic [31:0] d, a, rnd;
    checks = 0; failures = 0;
    for (int i = 0; i < 64; i++) exp_mem[i] = 32'h0;
    rstn = 1'b0;
    s_axil_awaddr = '0; s_axil_awvalid = 0; s_axil_wdata = '0; s_axil_wstrb = '0;
    s_axil_wvalid = 0; s_axil_bready = 0; s_axil_araddr = '0; s_axil_arvalid = 0;
    s_axil_rready = 0;
    repeat (3) @(negedge clk);
    s_axil_awvalid = 1; s_axil_wvalid = 1; s_axil_arvalid = 1;
    #1;
    chk("rst_readies", {29'h0, s_axil_awready, s_axil_wready, s_axil_arready}, 32'h0);
    chk("rst_outputs", {28'h0, sys_if_wen, s_axil_bvalid, s_axil_rvalid, |sys_if_addr}, 32'h0);
    chk("rst_wdata", sys_if_wdata, 32'h0);
    s_axil_awvalid = 0; s_axil_wvalid = 0; s_axil_arvalid = 0;
    @(negedge clk);
    rstn = 1'b1;

    // Write and read contending from reset: write wins first, then alternation.
    d = $urandom; wen0 = wen_cnt;
    @(negedge clk);
    s_axil_awaddr = 32'h20; s_axil_wdata = d; s_axil_wstrb = 4'hF; s_axil_araddr = 32'h20;
    s_axil_awvalid = 1; s_axil_wvalid = 1; s_axil_arvalid = 1; s_axil_bready = 1; s_axil_rready = 1;
    n = 0; both = 0; order = '0;
    for (int t = 0; t < 100 && n < 4; t++) begin
      #1;
      if (s_axil_awready && s_axil_arready) both++;
      if (s_axil_awvalid && s_axil_awready && s_axil_wvalid && s_axil_wready) begin
        order[n] = 1'b1; n++;
      end else if (s_axil_arvalid && s_axil_arready) begin
        order[n] = 1'b0; n++;
      end
      @(negedge clk);
    end
    s_axil_awvalid = 0; s_axil_wvalid = 0; s_axil_arvalid = 0;
    repeat (8) @(negedge clk);
    s_axil_bready = 0; s_axil_rready = 0;
    chk("arb_grants", 32'(n), 32'd4);
    chk("arb_order", 32'(order), 32'b0101);
    chk("arb_ready_overlap", 32'(both), 32'd0);
    chk("arb_wen_count", 32'(wen_cnt - wen0), 32'd2);
    exp_mem[8] = d;
    do_read(32'h20, 1);

    do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
    do_read(32'h10, 0);
    do_write(32'h14, 32'h11223344, 4'hF, 0, 0);
    do_write(32'h14, 32'hAABBCCDD, 4'b0101, 0, 1);
    do_read(32'h14, 0);
    do_write(32'h100, 32'h12345678, 4'hF, 0, 0);
    do_read(32'h204, 2);
    do_write(32'h18, $urandom, 4'hF, 3, 5);
    do_write(32'h18, $urandom, 4'h0, 0, 1);
    do_read(32'h18, 0);

    for (int i = 0; i < 16; i++) begin
      rnd = $urandom;
      a = (rnd[3:0] == 4'hF) ? 32'h0000_0100 << rnd[5:4] : 32'($urandom_range(0, 63)) << 2;
      do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 2));
      a = (rnd[7:4] == 4'hE) ? 32'h8000_0000 : 32'($urandom_range(0, 63)) << 2;
      do_read(a, $urandom_range(0, 2));
    end

    // Reset while a read-modify-write is in flight.
    wen0 = wen_cnt;
    @(negedge clk);
    s_axil_awaddr = 32'h30; s_axil_wdata = $urandom; s_axil_wstrb = 4'b0011;
    s_axil_awvalid = 1; s_axil_wvalid = 1;
    #1;
    chk("rmw_rst_hs", 32'(s_axil_awready && s_axil_wready), 32'd1);
    @(negedge clk);
    s_axil_awvalid = 0; s_axil_wvalid = 0; rstn = 0;
    @(negedge clk);
    chk("rmw_rst_outs", {29'h0, sys_if_wen, s_axil_bvalid, s_axil_awready}, 32'h0);
    chk("rmw_rst_addr", sys_if_addr, 32'h0);
    chk("rmw_rst_wdata", sys_if_wdata, 32'h0);
    rstn = 1;
    @(negedge clk);
    #1;
    chk("rmw_rst_idle", 32'(s_axil_awready), 32'd1);
    chk("rmw_rst_no_wen", 32'(wen_cnt - wen0), 32'd0);

    // Reset while a read response is pending.
    @(negedge clk);
    s_axil_araddr = 32'h14; s_axil_arvalid = 1;
    #1;
    chk("rresp_rst_hs", 32'(s_axil_arready), 32'd1);
    @(negedge clk);
    s_axil_arvalid = 0;
    @(negedge clk);
    chk("rresp_rst_pre", 32'(s_axil_rvalid), 32'd1);
    rstn = 0;
    @(negedge clk);
    chk("rresp_rst_outs", {29'h0, s_axil_rvalid, sys_if_wen, |s_axil_rresp}, 32'h0);
    chk("rresp_rst_rdata", s_axil_rdata, 32'h0);
    rstn = 1;
    do_write(32'h30, 32'hCAFE0123, 4'hF, 0, 0);
    do_read(32'h30, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
